// File: rtl/repeat_evt_sched.sv
// repeat_evt_sched: shared engine for "result = repeat(count) @(posedge evt) data" commits.
// Latency: count<=0 -> done_valid the cycle after grant; count=N -> the cycle after the Nth counted evt rise.
// Backpressure: requesters hold req_valid until req_ready; the result is held in DONE until done_ready.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   per-requester request strobe / one-hot grant (grant cycle only)
//   req_count         packed signed repeat counts, requester i at [i*CW +: CW]
//   req_data          packed data to commit, requester i at [i*DW +: DW]
//   evt_in            event input, synchronous to clk; rising edges are counted
//   done_valid/ready  result handshake; done_id/done_data held stable while valid
//   busy              engine not IDLE
module repeat_evt_sched #(
  parameter int NREQ = 2,
  parameter int CW   = 8,
  parameter int DW   = 8,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*CW-1:0]   req_count,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 evt_in,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [IDW-1:0]       done_id,
  output logic [DW-1:0]        done_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_ptr_nxt;
  logic            evt_d;
  logic            evt_rise;
  // A positive CW-bit signed count never needs its sign bit.
  logic [CW-2:0]   remaining;
  logic [CW-2:0]   remaining_nxt;
  logic [IDW-1:0]  done_id_nxt;
  logic [DW-1:0]   done_data_nxt;

  logic            grant_found;
  int              grant_idx;
  logic [CW-1:0]   grant_count;
  logic [DW-1:0]   grant_data;
  logic            count_nonpos;

  assign evt_rise = evt_in & ~evt_d;

  // Round-robin scan starting at rr_ptr and wrapping; first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant_found = 1'b1;
        grant_idx   = (int'(rr_ptr) + k) % NREQ;
      end
    end
  end

  assign grant_count  = req_count[grant_idx*CW +: CW];
  assign grant_data   = req_data[grant_idx*DW +: DW];
  // Sign bit covers every negative count; the zero compare covers count==0.
  assign count_nonpos = grant_count[CW-1] | (grant_count == '0);

  always_comb begin
    state_nxt     = state;
    rr_ptr_nxt    = rr_ptr;
    remaining_nxt = remaining;
    done_id_nxt   = done_id;
    done_data_nxt = done_data;
    req_ready     = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          done_id_nxt          = IDW'(grant_idx);
          done_data_nxt        = grant_data;
          rr_ptr_nxt           = IDW'((grant_idx + 1) % NREQ);
          // An evt rise in this grant cycle is deliberately not counted.
          if (count_nonpos) begin
            state_nxt = DONE;
          end else begin
            remaining_nxt = grant_count[CW-2:0];
            state_nxt     = WAIT;
          end
        end
      end
      WAIT: begin
        if (evt_rise) begin
          if (remaining == (CW-1)'(1)) begin
            state_nxt = DONE;
          end else begin
            remaining_nxt = remaining - (CW-1)'(1);
          end
        end
      end
      DONE: begin
        if (done_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A request presented while reset is asserted is never granted.
    if (rst) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      evt_d     <= 1'b0;
      remaining <= '0;
      done_id   <= '0;
      done_data <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      evt_d     <= evt_in;
      remaining <= remaining_nxt;
      done_id   <= done_id_nxt;
      done_data <= done_data_nxt;
    end
  end

  assign done_valid = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_repeat_evt_sched.sv
// Bench for repeat_evt_sched: table of single-requester commits, then hand-written
// sequences for reset in WAIT, round-robin alternation and done backpressure.
module tb_repeat_evt_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_count;
  logic [15:0] req_data;
  logic        evt_in;
  logic        done_valid;
  logic        done_ready;
  logic [0:0]  done_id;
  logic [7:0]  done_data;
  logic        busy;

  repeat_evt_sched #(.NREQ(2), .CW(8), .DW(8), .IDW(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_count  (req_count),
    .req_data   (req_data),
    .evt_in     (evt_in),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_id    (done_id),
    .done_data  (done_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [0:0] id;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] cnt;
    logic [7:0] dat;
    int         off;
    int         lat;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: done id %0d data 0x%0h with no expected entry", done_id, done_data);
    end else begin
      e = sb.pop_front();
      chk("done_id", 32'(done_id), 32'(e.id));
      chk("done_data", 32'(done_data), 32'(e.data));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // evt_in toggles every 2 cycles; with off=0 rises land on r=2,6,10...
  function automatic logic evt_at(input int r, input int off);
    return ((r + off) % 4) >= 2;
  endfunction

  task automatic sb_push(input int id, input logic [7:0] dat);
    exp_t e;
    e.id   = 1'(id);
    e.data = dat;
    sb.push_back(e);
  endtask

  // One request from a single requester, granted at relative cycle 0;
  // exp_lat is the relative cycle where done_valid must first appear.
  task automatic run_txn(input int id, input logic [7:0] cnt, input logic [7:0] dat,
                         input int off, input int exp_lat);
    int   r;
    logic seen;
    req_valid  = '0;
    evt_in     = 1'b0;
    done_ready = 1'b1;
    cyc();
    cyc();
    req_valid  = 2'(1 << id);
    req_count  = '0;
    req_count[id*8 +: 8] = cnt;
    req_data   = '0;
    req_data[id*8 +: 8]  = dat;
    evt_in     = evt_at(0, off);
    #1;
    chk("grant", 32'(req_ready), 32'(1 << id));
    sb_push(id, dat);
    r    = 0;
    seen = 1'b0;
    while (!seen && r < 600) begin
      cyc();
      r++;
      req_valid = '0;
      req_data  = ~req_data;
      evt_in    = evt_at(r, off);
      #1;
      if (done_valid) seen = 1'b1;
      else if (r == 1) chk("busy_wait", 32'(busy), 32'd1);
    end
    chk("latency", 32'(r), 32'(exp_lat));
    if (seen) sb_check();
    cyc();
    #1;
    chk("idle_after", 32'({busy, done_valid}), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   r;
    int   turn;
    int   dones;
    logic ghost;

    tbl[0] = '{0, 8'd3,   8'hA5, 0, 11};
    tbl[1] = '{0, 8'd0,   8'h3C, 0, 1};
    tbl[2] = '{0, 8'hFF,  8'h55, 0, 1};
    tbl[3] = '{0, 8'd1,   8'h5A, 2, 5};
    tbl[4] = '{1, 8'd2,   8'hC3, 2, 9};
    tbl[5] = '{1, 8'h80,  8'h7E, 2, 1};
    tbl[6] = '{0, 8'h7F,  8'h81, 0, 507};

    rst        = 1'b1;
    req_valid  = '0;
    req_count  = '0;
    req_data   = '0;
    evt_in     = 1'b0;
    done_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_done_data", 32'(done_data), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    for (int v = 0; v < 7; v++) begin
      run_txn(tbl[v].id, tbl[v].cnt, tbl[v].dat, tbl[v].off, tbl[v].lat);
    end

    // Reset while WAIT holds remaining=2: request is dropped silently.
    req_valid  = 2'b01;
    req_count  = {8'd0, 8'd3};
    req_data   = {8'h00, 8'hEE};
    evt_in     = evt_at(0, 0);
    done_ready = 1'b1;
    #1;
    chk("rw_grant", 32'(req_ready), 32'b01);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      req_valid = '0;
      evt_in    = evt_at(k, 0);
      if (k == 4) begin
        #1;
        chk("rw_busy", 32'(busy), 32'd1);
        rst = 1'b1;
      end
    end
    cyc();
    rst = 1'b0;
    evt_in = evt_at(5, 0);
    #1;
    chk("rw_done_valid", 32'(done_valid), 32'd0);
    chk("rw_busy_clr", 32'(busy), 32'd0);
    chk("rw_done_id", 32'(done_id), 32'd0);
    chk("rw_done_data", 32'(done_data), 32'd0);
    chk("rw_req_ready", 32'(req_ready), 32'd0);
    ghost = 1'b0;
    for (int k = 6; k < 26; k++) begin
      cyc();
      evt_in = evt_at(k, 0);
      #1;
      if (done_valid) ghost = 1'b1;
    end
    chk("rw_no_ghost_done", 32'(ghost), 32'd0);
    // Fresh request from requester 1 also brings rr_ptr back to 0.
    run_txn(1, 8'd1, 8'h42, 0, 3);

    // Both requesters valid continuously: grants must alternate 0,1,0,1.
    req_valid  = 2'b11;
    req_count  = {8'd1, 8'd1};
    req_data   = {8'hB1, 8'hB0};
    done_ready = 1'b1;
    turn  = 0;
    dones = 0;
    r     = 0;
    while (dones < 4 && r < 200) begin
      evt_in = evt_at(r, 0);
      #1;
      chk("rr_one_hot", 32'($countones(req_ready) <= 1), 32'd1);
      if (req_ready != '0) begin
        chk("rr_grant", 32'(req_ready), 32'(1 << turn));
        sb_push(turn, (turn == 1) ? 8'hB1 : 8'hB0);
        turn = 1 - turn;
      end
      if (done_valid) begin
        sb_check();
        dones++;
      end
      cyc();
      r++;
    end
    req_valid = '0;
    chk("rr_done_count", 32'(dones), 32'd4);

    // done_ready low for 5 cycles: result held, no new grant.
    evt_in     = 1'b0;
    cyc();
    req_valid  = 2'b01;
    req_count  = {8'd0, 8'd0};
    req_data   = {8'h77, 8'h99};
    done_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'b01);
    sb_push(0, 8'h99);
    cyc();
    req_valid = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      evt_in = ((k % 2) == 1);
      #1;
      chk("bp_valid", 32'(done_valid), 32'd1);
      chk("bp_id", 32'(done_id), 32'd0);
      chk("bp_data", 32'(done_data), 32'h99);
      chk("bp_no_grant", 32'(req_ready), 32'd0);
      cyc();
    end
    done_ready = 1'b1;
    #1;
    chk("bp_valid_hs", 32'(done_valid), 32'd1);
    sb_check();
    cyc();
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'b10);
    sb_push(1, 8'h77);
    cyc();
    req_valid = '0;
    #1;
    chk("bp_req1_done", 32'(done_valid), 32'd1);
    if (done_valid) sb_check();
    cyc();
    #1;
    chk("bp_idle", 32'(busy), 32'd0);

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
